// File: rtl/core_mul_seq.sv
// core_mul_seq
// Sequential mantissa/exponent multiplier for the posit datapath. Forms the
// exact 2*MANT_SIZE-bit product of two hidden-bit mantissas with a radix-2
// shift-add loop (MANT_SIZE iterations, no early exit), adds the total
// exponents, and normalizes the product into [1,2) with a single-step shift.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   te1, te2              operand total exponents (two's complement)
//   mant1, mant2          operand mantissas, hidden bit at MSB
//   out_valid / out_ready result handshake (valid only in DONE)
//   mant_out              normalized product, hidden bit at MSB
//   te_out                result total exponent (wraps modulo 2^TE_SIZE)
module core_mul_seq #(
  parameter int MANT_SIZE = 14,
  parameter int TE_SIZE   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TE_SIZE-1:0]     te1,
  input  logic [TE_SIZE-1:0]     te2,
  input  logic [MANT_SIZE-1:0]   mant1,
  input  logic [MANT_SIZE-1:0]   mant2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*MANT_SIZE-1:0] mant_out,
  output logic [TE_SIZE-1:0]     te_out
);

  localparam int PW = 2 * MANT_SIZE;
  localparam int CW = (MANT_SIZE > 1) ? $clog2(MANT_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_acc;
  logic [PW-1:0]        r_mcand;
  logic [MANT_SIZE-1:0] r_mplier;
  logic [TE_SIZE-1:0]   r_te_sum;
  logic [CW-1:0]        r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic                 w_norm_hi;
  logic [PW-1:0]        w_acc_next;

  // Partial-product add for the current multiplier bit.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_te_sum    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand    <= {{MANT_SIZE{1'b0}}, mant1};
            r_mplier   <= mant2;
            r_te_sum   <= te1 + te2;
            r_acc      <= '0;
            r_cnt      <= CW'(MANT_SIZE - 1);
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Product of two [1,2) values lies in [1,4): either already normalized or
  // one shift away. Unnormalized operands still get only the single shift.
  assign w_norm_hi = r_acc[PW-1];
  assign mant_out  = w_norm_hi ? r_acc : {r_acc[PW-2:0], 1'b0};
  assign te_out    = w_norm_hi ? (r_te_sum + TE_SIZE'(1)) : r_te_sum;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_core_mul_seq.sv
module tb_core_mul_seq;

  localparam int M  = 14;
  localparam int T  = 9;
  localparam int PW = 2 * M;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [T-1:0]  te1, te2;
  logic [M-1:0]  mant1, mant2;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] mant_out;
  logic [T-1:0]  te_out;

  typedef struct {
    logic [PW-1:0] mant;
    logic [T-1:0]  te;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  core_mul_seq #(.MANT_SIZE(M), .TE_SIZE(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .te1       (te1),
    .te2       (te2),
    .mant1     (mant1),
    .mant2     (mant2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .te_out    (te_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width multiply, then the single-step normalization rule.
  function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b,
                                 input logic [T-1:0] ea, input logic [T-1:0] eb);
    exp_t          r;
    logic [PW-1:0] p;
    logic [T-1:0]  s;
    p = PW'(a) * PW'(b);
    s = ea + eb;
    if (p[PW-1]) begin
      r.mant = p;
      r.te   = s + 9'd1;
    end else begin
      r.mant = p << 1;
      r.te   = s;
    end
    return r;
  endfunction

  // Present one operand pair at a negedge; accept occurs at the next posedge.
  task automatic send(input logic [M-1:0] a, input logic [M-1:0] b,
                      input logic [T-1:0] ea, input logic [T-1:0] eb);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
      return;
    end
    mant1 = a; mant2 = b; te1 = ea; te2 = eb;
    in_valid = 1'b1;
    q.push_back(model(a, b, ea, eb));
    @(negedge clk);
    in_valid = 1'b0;
    mant1 = '0; mant2 = '0; te1 = '0; te2 = '0;
  endtask

  // Wait for a result, compare against the scoreboard, then hand it off,
  // optionally stalling with random out_ready and checking hold stability.
  task automatic receive(input bit rnd);
    int   n = 0;
    bit   took;
    exp_t e;
    logic [PW-1:0] held_m;
    logic [T-1:0]  held_t;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
      return;
    end
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_result mant_out=%h (no pending operation)", mant_out);
      return;
    end
    e = q.pop_front();
    checks++;
    if (mant_out !== e.mant) begin
      errors++;
      $display("FAIL mant_out got=%h required=%h", mant_out, e.mant);
    end
    checks++;
    if (te_out !== e.te) begin
      errors++;
      $display("FAIL te_out got=%h required=%h", te_out, e.te);
    end
    held_m = mant_out;
    held_t = te_out;
    n = 0;
    do begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n > 20) out_ready = 1'b1;
      took = out_ready;
      @(negedge clk);
      n++;
      if (!took) begin
        checks++;
        if (mant_out !== held_m || te_out !== held_t || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold_stable mant=%h te=%h ov=%0b ir=%0b required mant=%h te=%h ov=1 ir=0",
                   mant_out, te_out, out_valid, in_ready, held_m, held_t);
        end
      end
    end while (!took);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_transfer out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || mant_out !== '0 || te_out !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ov=%0b mant=%h te=%h ir=%0b required 0/0/0/0",
               out_valid, mant_out, te_out, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic test_one_by_one();
    int n;
    send(14'h2000, 14'h2000, 9'd3, -9'sd5);
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL latency cycles=%0d required=15", n);
    end
    receive(1'b0);
  endtask

  task automatic test_directed();
    send(14'h3000, 14'h3000, 9'd2, 9'd1);
    receive(1'b0);
    send(14'h3FFF, 14'h3FFF, 9'd254, 9'd1);
    receive(1'b0);
    // Unnormalized operands: only a single shift is applied.
    send(14'h0800, 14'h0400, 9'd0, 9'd0);
    receive(1'b0);
  endtask

  task automatic test_backpressure();
    exp_t e;
    send(14'h2ABC, 14'h3123, 9'd100, 9'd50);
    // Pulses during BUSY must not be captured.
    repeat (3) @(negedge clk);
    in_valid = 1'b1; mant1 = 14'h3FFF; mant2 = 14'h3FFF; te1 = 9'd7; te2 = 9'd7;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid) @(negedge clk);
    e = q[0];
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 0);
      checks++;
      if (mant_out !== e.mant || te_out !== e.te || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold i=%0d mant=%h te=%h ov=%0b ir=%0b required mant=%h te=%h ov=1 ir=0",
                 i, mant_out, te_out, out_valid, in_ready, e.mant, e.te);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    receive(1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_capture out_valid=%0b required=0", out_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    send(14'h3000, 14'h3000, 9'd2, 9'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || mant_out !== '0 || te_out !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset ov=%0b mant=%h te=%h ir=%0b required 0/0/0/0",
               out_valid, mant_out, te_out, in_ready);
    end
    rst = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready in_ready=%0b required=1", in_ready);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL aborted_result out_valid=%0b required=0", out_valid);
    end
    send(14'h2000, 14'h2000, 9'd3, -9'sd5);
    receive(1'b0);
  endtask

  task automatic test_back_to_back();
    int   seen = 0;
    int   t_first = 0;
    int   t_second = 0;
    exp_t e;
    mant1 = 14'h2000; mant2 = 14'h3000; te1 = 9'd10; te2 = 9'd20;
    q.push_back(model(14'h2000, 14'h3000, 9'd10, 9'd20));
    q.push_back(model(14'h2000, 14'h3000, 9'd10, 9'd20));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 80 && seen < 2; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen++;
        if (seen == 1) t_first = n; else t_second = n;
        if (seen == 2) in_valid = 1'b0;
        e = q.pop_front();
        checks++;
        if (mant_out !== e.mant || te_out !== e.te) begin
          errors++;
          $display("FAIL b2b_result mant=%h te=%h required mant=%h te=%h", mant_out, te_out, e.mant, e.te);
        end
      end
    end
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (seen != 2 || (t_second - t_first) != M + 2) begin
      errors++;
      $display("FAIL b2b_throughput results=%0d spacing=%0d required 2/%0d", seen, t_second - t_first, M + 2);
    end
    q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [M-1:0] a, b;
    logic [T-1:0] ea, eb;
    for (int i = 0; i < 2000; i++) begin
      a  = {1'b1, 13'($urandom)};
      b  = {1'b1, 13'($urandom)};
      ea = 9'($urandom);
      eb = 9'($urandom);
      send(a, b, ea, eb);
      receive(1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    te1 = '0; te2 = '0; mant1 = '0; mant2 = '0;
    @(negedge clk);
    test_reset();
    test_one_by_one();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
